// File: rtl/hbmc_pkg.sv
// Shared types and constants for the HyperBus transfer sequencer:
// FSM state encoding, command/address bit layout and latency defaults.
package hbmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WR,
        ST_RD,
        ST_CSHI
    } hb_state_e;

    localparam int CA_W         = 48;
    localparam int CA_RNW_BIT   = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_HI    = 44;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_COL_HI    = 2;
    localparam int CA_COL_LO    = 0;

    localparam logic [3:0] LAT_DEFAULT = 4'd6;

    // Latency codes the device cannot honour fall back to the default.
    function automatic logic [3:0] lat_sanitize(input logic [3:0] lat);
        if (lat >= 4'd3 && lat <= 4'd7) begin
            return lat;
        end
        return LAT_DEFAULT;
    endfunction

endpackage

// File: rtl/hb_ca_build.sv
// Combinational formatter for the 48-bit HyperBus command/address word
// (linear burst, memory space).
module hb_ca_build
    import hbmc_pkg::*;
(
    input  logic            rnw_i,
    input  logic [31:0]     addr_i,
    output logic [CA_W-1:0] ca_o
);

    always_comb begin
        ca_o                         = '0;
        ca_o[CA_RNW_BIT]             = rnw_i;
        ca_o[CA_AS_BIT]              = 1'b0;
        ca_o[CA_BURST_BIT]           = 1'b1;
        ca_o[CA_ROW_HI:CA_ROW_LO]    = addr_i[31:3];
        ca_o[CA_COL_HI:CA_COL_LO]    = addr_i[2:0];
    end

endmodule

// File: rtl/hb_xfer_seq.sv
// HyperBus transfer sequencer: issues CA, waits initial latency, then streams
// write words or collects read words, with read timeout and CS# high spacing.
module hb_xfer_seq
    import hbmc_pkg::*;
#(
    parameter int DQ_WIDTH    = 8,
    parameter int LEN_W       = 9,
    parameter int CS_HIGH_MIN = 2,
    parameter int RD_TIMEOUT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [31:0]           cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [3:0]            cfg_latency,
    input  logic [15:0]           wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            wr_mask,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  cmd_done,
    output logic                  cs_n,
    output logic                  ck_en,
    output logic                  dq_t,
    output logic [2*DQ_WIDTH-1:0] dq_o,
    input  logic [2*DQ_WIDTH-1:0] dq_i,
    input  logic                  dq_i_vld,
    output logic                  rwds_t,
    output logic [1:0]            rwds_o,
    input  logic                  rwds_i
);

    localparam int DQW2  = 2 * DQ_WIDTH;
    localparam int CNT_W = LEN_W + 1;
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);

    hb_state_e         state_q;
    logic [31:0]       ca_lo_q;
    logic              rnw_q;
    logic [CNT_W-1:0]  len_q;
    logic [3:0]        lat_q;
    logic [7:0]        cnt_q;
    logic [4:0]        lat_cnt_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              cmd_ready_q, wr_ready_q, cs_n_q, ck_en_q, dq_t_q, rwds_t_q;
    logic [DQW2-1:0]   dq_o_q;
    logic [1:0]        rwds_o_q;
    logic [15:0]       rd_data_q;
    logic              rd_valid_q, rd_err_q, cmd_done_q;

    logic [CA_W-1:0]   ca_d;
    logic [CNT_W-1:0]  wcnt_d;
    logic [CNT_W-1:0]  len_d;
    logic [4:0]        lat_d;
    logic              last_beat, rd_to, xfer_end;

    hb_ca_build u_ca_build (
        .rnw_i  (cmd_rnw),
        .addr_i (cmd_addr),
        .ca_o   (ca_d)
    );

    always_comb begin
        wcnt_d    = wcnt_q + 1'b1;
        len_d     = (cmd_len == '0) ? CNT_W'(1) : {1'b0, cmd_len};
        lat_d     = rwds_i ? {lat_q, 1'b0} : {1'b0, lat_q};
        last_beat = ((state_q == ST_WR && wr_valid) || (state_q == ST_RD && dq_i_vld))
                    && (wcnt_d == len_q);
        rd_to     = (state_q == ST_RD) && !dq_i_vld && (to_cnt_q == TO_W'(RD_TIMEOUT - 1));
        xfer_end  = last_beat || rd_to;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ca_lo_q     <= '0;
            rnw_q       <= 1'b0;
            len_q       <= '0;
            lat_q       <= '0;
            cnt_q       <= '0;
            lat_cnt_q   <= '0;
            wcnt_q      <= '0;
            to_cnt_q    <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            ck_en_q     <= 1'b0;
            dq_t_q      <= 1'b1;
            rwds_t_q    <= 1'b1;
            dq_o_q      <= '0;
            rwds_o_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            cmd_done_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            cmd_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= ST_CA;
                        cmd_ready_q <= 1'b0;
                        ca_lo_q     <= ca_d[31:0];
                        rnw_q       <= cmd_rnw;
                        len_q       <= len_d;
                        lat_q       <= lat_sanitize(cfg_latency);
                        cnt_q       <= '0;
                        wcnt_q      <= '0;
                        to_cnt_q    <= '0;
                        cs_n_q      <= 1'b0;
                        ck_en_q     <= 1'b1;
                        dq_t_q      <= 1'b0;
                        dq_o_q      <= DQW2'(ca_d[47:32]);
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_CA: begin
                    // RWDS during the first CA word signals doubled latency.
                    if (cnt_q == 8'd0) begin
                        lat_cnt_q <= lat_d - 5'd1;
                    end
                    if (cnt_q == 8'd2) begin
                        state_q <= ST_LAT;
                        dq_t_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 8'd1;
                        dq_o_q <= (cnt_q == 8'd0) ? DQW2'(ca_lo_q[31:16]) : DQW2'(ca_lo_q[15:0]);
                    end
                end
                ST_LAT: begin
                    if (lat_cnt_q == 5'd0) begin
                        state_q    <= rnw_q ? ST_RD : ST_WR;
                        wr_ready_q <= !rnw_q;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 5'd1;
                        if (lat_cnt_q == 5'd1 && !rnw_q) begin
                            dq_t_q   <= 1'b0;
                            rwds_t_q <= 1'b0;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_valid) begin
                        dq_o_q   <= DQW2'(wr_data);
                        rwds_o_q <= wr_mask;
                        wcnt_q   <= wcnt_d;
                    end
                end
                ST_RD: begin
                    if (dq_i_vld) begin
                        rd_data_q  <= 16'(dq_i);
                        rd_valid_q <= 1'b1;
                        wcnt_q     <= wcnt_d;
                        to_cnt_q   <= '0;
                    end else if (rd_to) begin
                        rd_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_CSHI: begin
                    if (cnt_q == 8'(CS_HIGH_MIN - 1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (xfer_end) begin
                state_q    <= ST_CSHI;
                cmd_done_q <= 1'b1;
                cnt_q      <= '0;
                wr_ready_q <= 1'b0;
                cs_n_q     <= 1'b1;
                ck_en_q    <= 1'b0;
                dq_t_q     <= 1'b1;
                rwds_t_q   <= 1'b1;
            end
        end
    end

    // Write beats pass straight to the ODDR so a stalled cycle stops the clock in place.
    assign dq_o      = (state_q == ST_WR && wr_valid) ? DQW2'(wr_data) : dq_o_q;
    assign rwds_o    = (state_q == ST_WR && wr_valid) ? wr_mask : rwds_o_q;
    assign ck_en     = (state_q == ST_WR) ? wr_valid : ck_en_q;
    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign cs_n      = cs_n_q;
    assign dq_t      = dq_t_q;
    assign rwds_t    = rwds_t_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign cmd_done  = cmd_done_q;

endmodule

// File: tb/tb_hb_xfer_seq.sv
// Directed bench for hb_xfer_seq: write, read, stalled write, len=0 read,
// read timeout and reset during a write burst.
module tb_hb_xfer_seq;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [3:0]  cfg_latency;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [1:0]  wr_mask;
    logic [15:0] rd_data;
    logic        rd_valid, rd_err, cmd_done;
    logic        cs_n, ck_en, dq_t;
    logic [15:0] dq_o, dq_i;
    logic        dq_i_vld;
    logic        rwds_t, rwds_i;
    logic [1:0]  rwds_o;

    int checks = 0;
    int errors = 0;

    hb_xfer_seq #(
        .DQ_WIDTH(8), .LEN_W(9), .CS_HIGH_MIN(2), .RD_TIMEOUT(32)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cfg_latency(cfg_latency),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mask(wr_mask),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .cmd_done(cmd_done),
        .cs_n(cs_n), .ck_en(ck_en), .dq_t(dq_t), .dq_o(dq_o),
        .dq_i(dq_i), .dq_i_vld(dq_i_vld),
        .rwds_t(rwds_t), .rwds_o(rwds_o), .rwds_i(rwds_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          lat_n, hi_n, first_rv, done_j, rv_n, ck_lo, early_done;
    logic        err_at_done;
    logic [15:0] rd_cap [2];
    logic [6:0]  pat;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = '0;
        cfg_latency = 4'd6; wr_data = '0; wr_valid = 1'b0; wr_mask = '0;
        dq_i = '0; dq_i_vld = 1'b0; rwds_i = 1'b0;
        rd_cap[0] = '0; rd_cap[1] = '0;

        // Reset state
        tick(); #1;
        chk("rst cs_n", 32'(cs_n), 32'd1);
        chk("rst dq_t", 32'(dq_t), 32'd1);
        chk("rst rwds_t", 32'(rwds_t), 32'd1);
        chk("rst ck_en", 32'(ck_en), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst dq_o", 32'(dq_o), 32'd0);
        chk("rst cmd_done", 32'(cmd_done), 32'd0);
        rst = 1'b0;
        tick(); #1;
        chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

        // A: write, rwds=0, lat=6, len=4, addr 0x1235; inputs scrambled after capture
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0000_1235; cmd_len = 9'd4;
        cfg_latency = 4'd6; rwds_i = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_addr = '1; cmd_len = '0; cfg_latency = 4'd3;
        #1;
        chk("A ca0", 32'(dq_o), 32'h2000);
        chk("A ca cs_n", 32'(cs_n), 32'd0);
        chk("A ca ck_en", 32'(ck_en), 32'd1);
        chk("A ca dq_t", 32'(dq_t), 32'd0);
        chk("A ca cmd_ready", 32'(cmd_ready), 32'd0);
        tick(); #1; chk("A ca1", 32'(dq_o), 32'h0246);
        tick(); #1; chk("A ca2", 32'(dq_o), 32'h0005);
        lat_n = 0; hi_n = 0;
        tick(); #1;
        while (!wr_ready && lat_n < 40) begin
            lat_n++;
            if (dq_t) hi_n++;
            tick(); #1;
        end
        chk("A lat cycles", 32'(lat_n), 32'd6);
        chk("A lat dq_t high", 32'(hi_n), 32'd5);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_data = 16'(16'hA001 + k); wr_mask = 2'(k);
            #1;
            chk("A wr dq_o", 32'(dq_o), 32'(16'hA001 + k));
            chk("A wr rwds_o", 32'(rwds_o), 32'(k));
            chk("A wr ck_en", 32'(ck_en), 32'd1);
            chk("A wr cmd_done", 32'(cmd_done), 32'd0);
            tick();
        end
        wr_valid = 1'b0; #1;
        chk("A done", 32'(cmd_done), 32'd1);
        chk("A cshi cs_n", 32'(cs_n), 32'd1);
        chk("A cshi ck_en", 32'(ck_en), 32'd0);
        chk("A cshi dq_t", 32'(dq_t), 32'd1);
        chk("A cshi rwds_t", 32'(rwds_t), 32'd1);
        chk("A cshi wr_ready", 32'(wr_ready), 32'd0);
        tick(); #1;
        chk("A cshi1 cmd_done", 32'(cmd_done), 32'd0);
        chk("A cshi1 cmd_ready", 32'(cmd_ready), 32'd0);
        tick(); #1;
        chk("A back idle", 32'(cmd_ready), 32'd1);

        // B: read, rwds=1 -> LAT 12; dq_i_vld held high from LAT0 with a running index
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h00AB_CDE7; cmd_len = 9'd2;
        cfg_latency = 4'd6; rwds_i = 1'b1;
        tick(); cmd_valid = 1'b0; #1;
        chk("B ca0", 32'(dq_o), 32'hA015);
        tick(); rwds_i = 1'b0; #1;
        chk("B ca1", 32'(dq_o), 32'h79BC);
        tick(); #1;
        chk("B ca2", 32'(dq_o), 32'h0007);
        first_rv = -1; done_j = -1; rv_n = 0; err_at_done = 1'bx;
        for (int j = 0; j < 40; j++) begin
            tick();
            dq_i = 16'(16'h5A00 + j); dq_i_vld = 1'b1;
            #1;
            if (rd_valid) begin
                if (first_rv < 0) first_rv = j;
                if (rv_n < 2) rd_cap[rv_n] = rd_data;
                rv_n++;
            end
            if (cmd_done) begin
                done_j = j; err_at_done = rd_err;
                break;
            end
        end
        chk("B first rd_valid cycle", 32'(first_rv), 32'd13);
        chk("B beat count", 32'(rv_n), 32'd2);
        chk("B rd_data0", 32'(rd_cap[0]), 32'h5A0C);
        chk("B rd_data1", 32'(rd_cap[1]), 32'h5A0D);
        chk("B done cycle", 32'(done_j), 32'd14);
        chk("B rd_err at done", 32'(err_at_done), 32'd0);

        // Next command (C) presented during CSHI: held off until IDLE
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0000_0008; cmd_len = 9'd4;
        cfg_latency = 4'd2; rwds_i = 1'b0;
        hi_n = 1;
        for (int j = 0; j < 10; j++) begin
            tick(); dq_i_vld = 1'b0; #1;
            if (cmd_ready) break;
            if (cs_n) hi_n++;
        end
        chk("B cs_n high cycles", 32'(hi_n), 32'd2);
        tick(); cmd_valid = 1'b0; #1;
        chk("C accept cs_n", 32'(cs_n), 32'd0);
        chk("C ca0", 32'(dq_o), 32'h2000);
        tick(); #1; chk("C ca1", 32'(dq_o), 32'h0001);
        tick(); #1;
        lat_n = 0;
        tick(); #1;
        while (!wr_ready && lat_n < 40) begin
            lat_n++;
            tick(); #1;
        end
        chk("C lat cycles (cfg=2)", 32'(lat_n), 32'd6);
        pat = 7'b1100011; ck_lo = 0; early_done = 0;
        for (int i = 0; i < 7; i++) begin
            wr_valid = pat[i]; wr_data = 16'(16'hC000 + i);
            #1;
            if (!ck_en) ck_lo++;
            if (cmd_done) early_done++;
            if (i == 3) chk("C stall hold dq_o", 32'(dq_o), 32'hC001);
            tick();
        end
        wr_valid = 1'b0; #1;
        chk("C ck_en low cycles", 32'(ck_lo), 32'd3);
        chk("C no early done", 32'(early_done), 32'd0);
        chk("C done after 4 beats", 32'(cmd_done), 32'd1);
        for (int j = 0; j < 10; j++) begin
            tick(); #1;
            if (cmd_ready) break;
        end

        // F: read, len=0 means one word, lat=3
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_0040; cmd_len = 9'd0;
        cfg_latency = 4'd3; rwds_i = 1'b0;
        tick(); cmd_valid = 1'b0; tick(); tick(); #1;
        done_j = -1;
        for (int j = 0; j < 40; j++) begin
            tick();
            dq_i = 16'(16'h7700 + j); dq_i_vld = 1'b1;
            #1;
            if (cmd_done) begin
                done_j = j;
                break;
            end
        end
        dq_i_vld = 1'b0;
        chk("F done cycle", 32'(done_j), 32'd4);
        chk("F rd_data", 32'(rd_data), 32'h7703);
        chk("F rd_valid", 32'(rd_valid), 32'd1);
        for (int j = 0; j < 10; j++) begin
            tick(); #1;
            if (cmd_ready) break;
        end

        // D: read timeout, no dq_i_vld
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_0100; cmd_len = 9'd1;
        cfg_latency = 4'd3; rwds_i = 1'b0;
        tick(); cmd_valid = 1'b0; tick(); tick(); #1;
        done_j = -1; err_at_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick(); #1;
            if (cmd_done) begin
                done_j = k; err_at_done = rd_err;
                break;
            end
        end
        chk("D done cycle", 32'(done_j), 32'd35);
        chk("D rd_err with done", 32'(err_at_done), 32'd1);
        tick(); #1;
        chk("D rd_err one cycle", 32'(rd_err), 32'd0);
        chk("D cmd_done one cycle", 32'(cmd_done), 32'd0);
        tick(); #1;
        chk("D back idle", 32'(cmd_ready), 32'd1);

        // E: reset asserted in WR
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h0000_0020; cmd_len = 9'd4;
        cfg_latency = 4'd3; rwds_i = 1'b0;
        tick(); cmd_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick(); #1;
            if (wr_ready) break;
        end
        chk("E reach WR", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_data = 16'hE001;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; wr_valid = 1'b0; #1;
        chk("E rst cs_n", 32'(cs_n), 32'd1);
        chk("E rst dq_t", 32'(dq_t), 32'd1);
        chk("E rst ck_en", 32'(ck_en), 32'd0);
        chk("E rst cmd_done", 32'(cmd_done), 32'd0);
        chk("E rst wr_ready", 32'(wr_ready), 32'd0);
        tick(); #1;
        chk("E after rst cmd_done", 32'(cmd_done), 32'd0);
        chk("E after rst cmd_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
